// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing constants for the alarm controller.
// Imported by the controller top level and its countdown timer.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4,
    ST_SILENT      = 3'd5
  } state_t;

  localparam logic [7:0] ALARM_CNT_MAX = 8'd255;

  localparam int DEF_EXIT_CYCLES  = 16;
  localparam int DEF_ENTRY_CYCLES = 8;
  localparam int DEF_SIREN_CYCLES = 32;
  localparam int DEF_CNT_W        = 8;

  function automatic logic is_armed(input state_t s);
    return (s == ST_ARMED) || (s == ST_ENTRY_DELAY) ||
           (s == ST_ALARM) || (s == ST_SILENT);
  endfunction

  function automatic logic is_pending(input state_t s);
    return (s == ST_EXIT_DELAY) || (s == ST_ENTRY_DELAY);
  endfunction

endpackage

// File: rtl/alarm_controller_delay_timer.sv
// Loadable down-counter shared by the exit, entry and siren delays.
// Holds at zero; the controller decides when and what to load.
module delay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_controller.sv
// House alarm sequencer: arm/disarm, exit and entry delays, timed siren,
// silent hold until the sensor clears, and a saturating alarm event count.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int EXIT_CYCLES  = DEF_EXIT_CYCLES,
  parameter int ENTRY_CYCLES = DEF_ENTRY_CYCLES,
  parameter int SIREN_CYCLES = DEF_SIREN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alert,
  input  logic       arm,
  input  logic       disarm,
  output logic       siren,
  output logic       armed,
  output logic       pending,
  output logic [2:0] state,
  output logic [7:0] alarm_count
);

  if ((EXIT_CYCLES < 1) || (EXIT_CYCLES > (1 << CNT_W)) ||
      (ENTRY_CYCLES < 1) || (ENTRY_CYCLES > (1 << CNT_W)) ||
      (SIREN_CYCLES < 1) || (SIREN_CYCLES > (1 << CNT_W))) begin : g_bad_cfg
    $error("alarm_controller: a cycle parameter is outside 1..2**CNT_W");
  end

  // Timed states load N-1 so that the zero-exit lands after exactly N cycles.
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             timer_en;
  logic             zero;
  logic             count_inc;

  delay_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(load_value),
    .enable    (timer_en),
    .zero      (zero)
  );

  assign timer_en = (state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY) ||
                    (state_q == ST_ALARM);

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_value = '0;
    count_inc  = 1'b0;
    if (disarm && (state_q != ST_DISARMED)) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm && !disarm) begin
            state_d    = ST_EXIT_DELAY;
            load       = 1'b1;
            load_value = EXIT_LD;
          end
        end
        ST_EXIT_DELAY: begin
          if (zero) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (alert) begin
            state_d    = ST_ENTRY_DELAY;
            load       = 1'b1;
            load_value = ENTRY_LD;
          end
        end
        ST_ENTRY_DELAY: begin
          if (zero) begin
            state_d    = ST_ALARM;
            load       = 1'b1;
            load_value = SIREN_LD;
            count_inc  = 1'b1;
          end
        end
        ST_ALARM: begin
          if (zero) state_d = ST_SILENT;
        end
        ST_SILENT: begin
          // A sensor still reporting open keeps us here without re-arming the siren.
          if (!alert) state_d = ST_ARMED;
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DISARMED;
      siren       <= 1'b0;
      armed       <= 1'b0;
      pending     <= 1'b0;
      alarm_count <= '0;
    end else begin
      state_q <= state_d;
      siren   <= (state_d == ST_ALARM);
      armed   <= is_armed(state_d);
      pending <= is_pending(state_d);
      if (count_inc && (alarm_count != ALARM_CNT_MAX)) begin
        alarm_count <= alarm_count + 8'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random traffic,
// every cycle compared against a cycles-remaining behavioural model.
module tb_alarm_controller;

  localparam int EXIT_N  = 16;
  localparam int ENTRY_N = 8;
  localparam int SIREN_N = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alert = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       siren;
  logic       armed;
  logic       pending;
  logic [2:0] state;
  logic [7:0] alarm_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode code, cycles left in the current timed mode, event count.
  int m_mode  = 0;
  int m_left  = 0;
  int m_count = 0;

  alarm_controller dut (
    .clk        (clk),
    .rst        (rst),
    .alert      (alert),
    .arm        (arm),
    .disarm     (disarm),
    .siren      (siren),
    .armed      (armed),
    .pending    (pending),
    .state      (state),
    .alarm_count(alarm_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_left  = 0;
    m_count = 0;
  endtask

  task automatic model_step(input logic a, input logic ar, input logic d);
    if (d && m_mode != 0) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (ar && !d) begin m_mode = 1; m_left = EXIT_N; end
        1: if (m_left == 1) m_mode = 2; else m_left--;
        2: if (a) begin m_mode = 3; m_left = ENTRY_N; end
        3: if (m_left == 1) begin
             m_mode  = 4;
             m_left  = SIREN_N;
             m_count = (m_count < 255) ? m_count + 1 : 255;
           end else m_left--;
        4: if (m_left == 1) m_mode = 5; else m_left--;
        5: if (!a) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic s, am, p;
    s  = (m_mode == 4);
    am = (m_mode >= 2);
    p  = (m_mode == 1) || (m_mode == 3);
    return {18'd0, 3'(m_mode), s, am, p, 8'(m_count)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {18'd0, state, siren, armed, pending, alarm_count};
  endfunction

  task automatic cyc(input string tag, input logic a, input logic ar, input logic d);
    @(negedge clk);
    alert  = a;
    arm    = ar;
    disarm = d;
    @(posedge clk);
    model_step(a, ar, d);
    #1;
    check_val(tag, dut_vec(), model_vec());
  endtask

  task automatic idle(input string tag, input int n, input logic a);
    for (int i = 0; i < n; i++) cyc(tag, a, 1'b0, 1'b0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val("reset_async", dut_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("reset_idle", 1'b0, 1'b0, 1'b0);

    // Exit delay with an ignored alert pulse.
    cyc("arm", 1'b0, 1'b1, 1'b0);
    idle("exit", 5, 1'b0);
    cyc("exit_alert", 1'b1, 1'b0, 1'b0);
    idle("exit", 12, 1'b0);
    check_val("armed_after_exit", dut_vec(), {18'd0, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0});

    // Single-cycle alert: entry, siren, one silent cycle, back to armed.
    cyc("alert_pulse", 1'b1, 1'b0, 1'b0);
    idle("entry", ENTRY_N, 1'b0);
    check_val("siren_on", {31'd0, siren}, 32'd1);
    idle("siren", SIREN_N + 2, 1'b0);
    check_val("count_one", {24'd0, alarm_count}, 32'd1);

    // Disarm during entry delay.
    cyc("alert2", 1'b1, 1'b0, 1'b0);
    idle("entry2", 3, 1'b0);
    cyc("disarm_entry", 1'b0, 1'b0, 1'b1);
    check_val("disarmed_state", {29'd0, state}, 32'd0);
    idle("after_disarm", ENTRY_N + 2, 1'b0);

    // Alert held through alarm: siren ends, silent held, release rearms.
    cyc("arm2", 1'b0, 1'b1, 1'b0);
    idle("exit2", EXIT_N, 1'b0);
    idle("held", 1 + ENTRY_N + SIREN_N + 5, 1'b1);
    check_val("silent_held", {29'd0, state}, 32'd5);
    idle("release", 3, 1'b0);
    check_val("no_second_alarm", {24'd0, alarm_count}, 32'd2);

    // arm with disarm in DISARMED, then disarm mid-alarm.
    cyc("disarm_from_armed", 1'b0, 1'b0, 1'b1);
    cyc("arm_and_disarm", 1'b0, 1'b1, 1'b1);
    check_val("arm_disarm_stay", {29'd0, state}, 32'd0);
    cyc("arm3", 1'b0, 1'b1, 1'b0);
    idle("exit3", EXIT_N, 1'b0);
    cyc("alert3", 1'b1, 1'b0, 1'b0);
    idle("to_alarm", ENTRY_N + 4, 1'b0);
    cyc("disarm_alarm", 1'b0, 1'b0, 1'b1);
    check_val("siren_armed_off", {30'd0, siren, armed}, 32'd0);

    // Saturation of the event counter.
    cyc("arm4", 1'b0, 1'b1, 1'b0);
    idle("exit4", EXIT_N, 1'b0);
    for (int e = 0; e < 260; e++) begin
      cyc("sat_alert", 1'b1, 1'b0, 1'b0);
      idle("sat_run", ENTRY_N + SIREN_N + 3, 1'b0);
    end
    check_val("count_saturated", {24'd0, alarm_count}, 32'd255);

    // Asynchronous reset mid-alarm.
    cyc("alert5", 1'b1, 1'b0, 1'b0);
    idle("to_alarm5", ENTRY_N + 5, 1'b0);
    check_val("in_alarm", {31'd0, siren}, 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val("async_rst_mid_alarm", dut_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic ra, rr, rd;
      ra = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 63) == 0);
      cyc("random", ra, rr, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Consumer end of the sensor alert line: takes the registered `alert` from the door/window sensor block and decides what the house does about it.
- Implements arm/disarm, exit delay, entry delay, a timed siren, a post-siren silent hold, and a saturating alarm event counter.
- Sits between the sensor block and the siren driver / status LEDs.

Parameters:
- EXIT_CYCLES, 16, cycles spent in EXIT_DELAY after arming (legal range 1..2^CNT_W).
- ENTRY_CYCLES, 8, cycles spent in ENTRY_DELAY before the siren sounds (legal range 1..2^CNT_W).
- SIREN_CYCLES, 32, cycles the siren stays on per alarm event (legal range 1..2^CNT_W).
- CNT_W, 8, width of the shared countdown counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- alert  in  1  registered intrusion alert from the sensor block; level-sensitive.
- arm  in  1  arm request; single-cycle pulse.
- disarm  in  1  disarm request; single-cycle pulse.
- siren  out  1  siren enable.
- armed  out  1  system armed indicator.
- pending  out  1  beeper enable during the exit and entry delays.
- state  out  3  current state code, for debug.
- alarm_count  out  8  number of alarm events, saturating.

Behaviour:
- Reset: rst is asynchronous and active-high. While it is asserted, state=DISARMED, counter=0, alarm_count=0, and siren, armed and pending are all 0.
  - These values take effect immediately, with no clock edge needed, including when reset hits mid-ALARM.
- State codes: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, SILENT=5. Codes 6 and 7 are illegal and go to DISARMED on the next edge.
- Outputs are all registered and decoded from the state register, so they update on the same edge as the state.
  - siren=1 only in ALARM.
  - armed=1 in ARMED, ENTRY_DELAY, ALARM and SILENT.
  - pending=1 in EXIT_DELAY and ENTRY_DELAY.
- Inputs are sampled on the rising clk edge. Decision latency is 1 cycle: an input sampled at edge N is visible in the state after edge N.
- Priority: disarm overrides everything.
  - disarm=1 in any state other than DISARMED goes to DISARMED on the next edge.
  - arm is only acted on in DISARMED.
  - arm and disarm both high in DISARMED keeps the block in DISARMED.
- Counter: loaded with X_CYCLES-1 on the edge that enters a timed state, then decremented once per cycle. The exit edge is taken when the counter is 0, so each timed state lasts exactly X_CYCLES cycles.
- DISARMED:
  - arm=1 -> EXIT_DELAY, counter loaded with EXIT_CYCLES-1.
- EXIT_DELAY:
  - alert is ignored.
  - counter==0 -> ARMED.
- ARMED:
  - alert=1 -> ENTRY_DELAY, counter loaded with ENTRY_CYCLES-1.
- ENTRY_DELAY:
  - alert going low does not cancel the delay; only disarm does.
  - counter==0 -> ALARM, counter loaded with SIREN_CYCLES-1, alarm_count incremented.
- ALARM:
  - counter==0 -> SILENT.
- SILENT:
  - siren=0.
  - alert=0 -> ARMED.
  - While alert=1, stays in SILENT with no re-trigger, so a door left open cannot cause repeated alarms.
- alarm_count: increments once per entry into ALARM and saturates at 255. Only rst clears it; disarm does not.
- Counter width: CNT_W bits, no wrap in legal operation. Parameter values outside the legal range are a configuration error, checked by an elaboration-time assertion.

Decomposition:
- Package alarm_pkg holds:
  - the state encoding constants and typedef (3-bit);
  - ALARM_CNT_MAX=255;
  - default cycle constants shared with the top level.
- One natural sub-module: delay_timer.
  - Inputs: load, load_value[CNT_W], enable.
  - Output: zero flag.
  - The FSM owns all the load decisions.

Test Plan (default parameters):
1. Reset, then arm pulse -> pending=1 for exactly 16 cycles with armed=0, then armed=1 and pending=0. An alert pulse inside the exit delay has no effect.
2. ARMED, alert high for 1 cycle -> pending=1 for 8 cycles, then siren=1 for 32 cycles and alarm_count=1. Alert already low -> SILENT lasts 1 cycle, then back to ARMED.
3. ENTRY_DELAY, disarm at delay cycle 3 -> state=0 on the next edge, siren never asserts, alarm_count stays 0.
4. ALARM with alert held high -> siren drops after 32 cycles, state=5 held. Release alert -> ARMED next edge, with no second alarm counted.
5. arm and disarm together in DISARMED -> stays DISARMED. disarm mid-ALARM -> siren=0 and armed=0 on the next edge.
6. Drive 260 alarm events -> alarm_count saturates at 255. Assert rst asynchronously mid-ALARM -> siren, armed and alarm_count go to 0 before the next clk edge.
